// File: rtl/brs_out_capture.sv
// brs_out_capture: captures bytes from the BRS 8-bit result bus into a small
// FIFO and re-transmits them as UART-style frames (start, 8 data LSB first,
// optional even parity, stop) on a single idle-high pin.
// Optional feature macro: BRS_CAP_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit.
module brs_out_capture #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               cap_data,
  input  logic                     cap_valid,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Serialiser state
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef BRS_CAP_PARITY_EN
  logic          parity_bit;
`endif

  logic       full;
  logic       empty;
  logic       push;
  logic       drop;
  logic       pop;
  logic       bit_end;
  logic [7:0] head;

  // Full is judged on the pre-edge occupancy, so a same-edge pop never
  // makes room for a push arriving while the FIFO is full.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = cap_valid & ena & ~full;
  assign drop    = cap_valid & ena & full;
  assign bit_end = (timer == T_LAST);
  assign head    = mem[rd_ptr];

  // A new frame is loaded either from idle or straight out of a finished
  // stop bit, which is what gives back-to-back frames with no idle gap.
  assign pop = ena & ~empty &
               ((state == S_IDLE) | ((state == S_STOP) & bit_end));

  // Byte storage; no reset so it can map onto RAM resources
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cap_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Frame serialiser; tx and busy come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
`ifdef BRS_CAP_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          timer <= '0;
          if (pop) begin
            shreg      <= head;
`ifdef BRS_CAP_PARITY_EN
            parity_bit <= ^head;
`endif
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
`ifdef BRS_CAP_PARITY_EN
              tx    <= parity_bit;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              // Shift the next bit down; old shreg[1] becomes the new LSB
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            timer <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              shreg      <= head;
`ifdef BRS_CAP_PARITY_EN
              parity_bit <= ^head;
`endif
              tx         <= 1'b0;
              state      <= S_START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brs_out_capture.sv
// Self-checking bench for brs_out_capture: directed steps plus a randomized
// phase, checked against a queue-based model and a frame decoder on tx.
module tb_brs_out_capture;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
`ifdef BRS_CAP_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       cap_valid = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       tx;
  logic       busy;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [7:0] exp_q[$];
  int         mcount = 0;
  bit         movf = 1'b0;
  bit         in_frame = 1'b0;
  int         cyc = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;

  brs_out_capture #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cap_data(cap_data),
    .cap_valid(cap_valid), .tx(tx), .busy(busy), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit position i of byte d
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (NBITS == 11 && i == 9) return ^d;
    return 1'b1;
  endfunction

  // Reference model and frame decoder, sampled on the falling edge
  initial begin
    int b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mcount = 0;
        movf = 1'b0;
        in_frame = 1'b0;
        cyc = 0;
        check("rst_tx", tx, 1);
        check("rst_count", count, 0);
      end else begin
        if (in_frame) begin
          cyc++;
          if (cyc == FLEN) in_frame = 1'b0;
        end
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          cyc = 0;
          check("pop_nonempty", (mcount > 0), 1);
          if (mcount > 0) mcount--;
        end
        if (in_frame) begin
          b = cyc / CPB;
          if (b == 0) check("start_bit", tx, 0);
          else if (b == NBITS - 1) check("stop_bit", tx, 1);
          else if (cyc % CPB == CPB / 2) begin
            if (b <= 8) rx_byte[b-1] = tx;
            else rx_par = tx;
          end
          if (cyc == FLEN - 1) begin
            check("frame_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame_byte", rx_byte, e);
`ifdef BRS_CAP_PARITY_EN
              check("parity_bit", rx_par, ^e);
`endif
            end
          end
        end
        check("busy", busy, in_frame);
        check("count", count, mcount);
        check("overflow", overflow, movf);
        // Input applied at the coming rising edge
        if (ena && cap_valid) begin
          if (mcount < DEPTH) begin
            exp_q.push_back(cap_data);
            mcount++;
          end else begin
            movf = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [7:0] d, input logic en);
    @(posedge clk);
    #1;
    cap_valid = v;
    cap_data  = d;
    ena       = en;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && count == 0) break;
    end
    check("drain_idle", {busy, count}, 0);
  endtask

  initial begin
    int busy_cycles;
    int busy_rises;
    int peak;
    logic prev_busy;
    int burst;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_count", count, 0);
    check("idle_overflow", overflow, 0);

    // 2: single byte, cycle-exact waveform
    step(1'b1, 8'hA5, 1'b1);
    @(posedge clk);
    #1 cap_valid = 1'b0;
    @(negedge clk);
    check("a5_pre_tx", tx, 1);
    check("a5_pre_count", count, 1);
    for (int c = 0; c < FLEN; c++) begin
      @(negedge clk);
      check("a5_tx", tx, frame_bit(8'hA5, c / CPB));
      check("a5_busy", busy, 1);
    end
    @(negedge clk);
    check("a5_end_busy", busy, 0);
    check("a5_end_tx", tx, 1);

    // 3: three consecutive pushes, contiguous frames
    busy_cycles = 0;
    busy_rises = 0;
    peak = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 3 * FLEN + 20; i++) begin
      @(posedge clk);
      #1;
      cap_valid = (i < 3);
      cap_data  = 8'(i + 1);
      @(negedge clk);
      if (busy) busy_cycles++;
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
      if (int'(count) > peak) peak = int'(count);
    end
    check("b2b_busy_cycles", busy_cycles, 3 * FLEN);
    check("b2b_busy_rises", busy_rises, 1);
    check("b2b_peak_ok", (peak >= 2 && peak <= 3), 1);
    check("b2b_final_count", count, 0);

    // 4: ena low ignores captures and holds off new frames
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      check("ena0_count", count, 0);
      check("ena0_tx", tx, 1);
    end
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_tx", tx, 1);
      check("hold_count", count, 1);
    end
    step(1'b0, 8'h00, 1'b1);
    wait_idle(3 * FLEN);

    // 5: overflow on 10 back-to-back pushes
    for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h10 + k), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("ovf_count_full", count, DEPTH);
    check("ovf_flag", overflow, 1);
    wait_idle((DEPTH + 3) * FLEN);
    check("ovf_sticky", overflow, 1);

    // 6: reset in the middle of a data bit
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    repeat (CPB * 4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_tx", tx, 1);
    end
    step(1'b1, 8'h07, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    wait_idle(4 * FLEN);

    // Randomized traffic with occasional bursts and ena drops
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(4, 12);
      step((burst > 0) || ($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 9) != 0));
      if (burst > 0) burst--;
    end
    step(1'b0, 8'h00, 1'b1);
    wait_idle((DEPTH + 3) * FLEN);
    check("rand_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
